// File: rtl/fetch_controller_pkg.sv
// Shared widths, Q-phase encoding and NOP word for the PIC16F fetch sequencer.
// No logic of its own.
// No flow control; constants and one helper only.
package fetch_controller_pkg;

  localparam int ADDR_WIDTH  = 13;
  localparam int INSTR_WIDTH = 14;
  localparam int STACK_DEPTH = 8;

  // A flushed slot presents an all-zero word, which the PIC16F decodes as NOP.
  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = '0;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } q_phase_e;

  // Q4 rolls over to Q1 through the natural 2-bit wrap.
  function automatic q_phase_e next_phase(input q_phase_e q);
    return q_phase_e'(q + 2'd1);
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Program memory read port: address/enable out of the sequencer, word back.
// Memory returns data one clock after mem_rd_en (registered read).
// No backpressure; the memory must accept every read.
interface fetch_controller_if #(
  parameter int ADDR_WIDTH  = fetch_controller_pkg::ADDR_WIDTH,
  parameter int INSTR_WIDTH = fetch_controller_pkg::INSTR_WIDTH
);

  logic                   mem_rd_en;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [INSTR_WIDTH-1:0] mem_instr;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_instr
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_instr
  );

endinterface

// File: rtl/fetch_controller_hw_stack.sv
// Circular return-address LIFO with sticky overflow/underflow flags.
// Push/pop take effect on the clock edge; top_dat_o is combinational from sp.
// No backpressure: a push when full overwrites the oldest entry, a pop when empty wraps.
module hw_stack #(
  parameter int DEPTH = fetch_controller_pkg::STACK_DEPTH,
  parameter int WIDTH = fetch_controller_pkg::ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic [WIDTH-1:0] top_dat_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam int SPW = $clog2(DEPTH);
  localparam logic [SPW-1:0] SP_ONE   = 1;
  localparam logic [SPW:0]   CNT_ONE  = 1;
  localparam logic [SPW:0]   CNT_FULL = (SPW+1)'(DEPTH);

  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d, sp_dec;
  logic [SPW:0]     count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // sp points at the next free slot, so the top of stack lives one below it.
  assign sp_dec    = sp_q - SP_ONE;
  assign top_dat_o = stk_q[sp_dec];
  assign ovf_o     = ovf_q;
  assign unf_o     = unf_q;

  // Pointer and occupancy arithmetic; count saturates at both ends while sp keeps wrapping.
  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (push_i) begin
      sp_d = sp_q + SP_ONE;
      if (count_q == CNT_FULL) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else if (pop_i) begin
      sp_d = sp_dec;
      if (count_q == '0) begin
        unf_d = 1'b1;
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  // Control state; the entry array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage: when full, slot sp already holds the oldest entry, so it is overwritten.
  always_ff @(posedge clk) begin
    if (push_i) begin
      stk_q[sp_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// PIC16F fetch sequencer: Q1..Q4 counter, program counter, IR and branch flush.
// One fetch per 4-clock instruction cycle; fetched word reaches ir at the next Q1 edge.
// stall freezes every register and suppresses mem_rd_en; memory has no backpressure.
module fetch_controller #(
  parameter int ADDR_WIDTH  = fetch_controller_pkg::ADDR_WIDTH,
  parameter int INSTR_WIDTH = fetch_controller_pkg::INSTR_WIDTH,
  parameter int STACK_DEPTH = fetch_controller_pkg::STACK_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   pc_load_en,
  input  logic [ADDR_WIDTH-1:0]  pc_load_addr,
  input  logic                   push_en,
  input  logic                   pop_en,
  fetch_controller_if.master     mem,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic                   ir_valid,
  output logic [1:0]             q_phase,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   stk_ovf,
  output logic                   stk_unf
);

  import fetch_controller_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = 1;

  q_phase_e               q_q, q_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   ir_vld_q, ir_vld_d;
  logic                   flush_q, flush_d;

  logic                   cmd_fire;
  logic                   do_pop, do_jump, do_push;
  logic [ADDR_WIDTH-1:0]  stk_top;

  // Commands only act on a live Q4 edge; reset drops anything pending.
  assign cmd_fire = (q_q == Q4) && !stall && !rst;
  assign do_pop   = cmd_fire && pop_en;
  assign do_jump  = cmd_fire && !pop_en && pc_load_en;
  assign do_push  = do_jump && push_en;

  // The Q4 fetch uses the pre-update pc; a command on that edge makes it stale, hence the flush.
  assign mem.mem_rd_en = (q_q == Q4) && !stall;
  assign mem.mem_addr  = pc_q;

  assign ir       = ir_q;
  assign ir_valid = ir_vld_q;
  assign q_phase  = q_q;
  assign pc       = pc_q;

  hw_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_stk (
    .clk        (clk),
    .rst        (rst),
    .push_i     (do_push),
    .pop_i      (do_pop),
    .push_dat_i (pc_q),
    .top_dat_o  (stk_top),
    .ovf_o      (stk_ovf),
    .unf_o      (stk_unf)
  );

  // Phase sequencing: IR load or NOP insertion at Q1, pc update/branch at Q4.
  always_comb begin
    q_d      = q_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ir_vld_d = ir_vld_q;
    flush_d  = flush_q;
    if (!stall) begin
      q_d = next_phase(q_q);
      if (q_q == Q1) begin
        if (flush_q) begin
          ir_d     = INSTR_WIDTH'(NOP_WORD);
          ir_vld_d = 1'b0;
          flush_d  = 1'b0;
        end else begin
          ir_d     = mem.mem_instr;
          ir_vld_d = 1'b1;
        end
      end
      if (q_q == Q4) begin
        if (do_pop) begin
          pc_d    = stk_top;
          flush_d = 1'b1;
        end else if (do_jump) begin
          pc_d    = pc_load_addr;
          flush_d = 1'b1;
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
    end
  end

  // Sequencer state; flush starts set so the first instruction cycle presents a NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q      <= Q1;
      pc_q     <= '0;
      ir_q     <= INSTR_WIDTH'(NOP_WORD);
      ir_vld_q <= 1'b0;
      flush_q  <= 1'b1;
    end else begin
      q_q      <= q_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ir_vld_q <= ir_vld_d;
      flush_q  <= flush_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: cycle table for reset/free-run/jump,
// then hand sequences for call/return, stack overflow/underflow, stall, wrap and mid-cycle reset.
// Memory model returns a registered word one clock after mem_rd_en.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst, stall, pc_load_en, push_en, pop_en;
  logic [12:0] pc_load_addr;
  logic [13:0] ir;
  logic        ir_valid;
  logic [1:0]  q_phase;
  logic [12:0] pc;
  logic        stk_ovf, stk_unf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_controller_if mif ();

  fetch_controller dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .pc_load_en   (pc_load_en),
    .pc_load_addr (pc_load_addr),
    .push_en      (push_en),
    .pop_en       (pop_en),
    .mem          (mif),
    .ir           (ir),
    .ir_valid     (ir_valid),
    .q_phase      (q_phase),
    .pc           (pc),
    .stk_ovf      (stk_ovf),
    .stk_unf      (stk_unf)
  );

  function automatic logic [13:0] memval(input logic [12:0] a);
    case (a)
      13'd0:   return 14'h0000;
      13'd1:   return 14'h30AB;
      13'd2:   return 14'h2800;
      default: return 14'h3000 | {1'b0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mif.mem_rd_en) mif.mem_instr <= memval(mif.mem_addr);
  end

  typedef struct {
    logic        r, s, ld, ps, pp;
    logic [12:0] a;
    logic [1:0]  q;
    logic [12:0] p;
    logic [13:0] i;
    logic        v, rd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, s, ld, ps, pp, input logic [12:0] a,
                              input logic [1:0] q, input logic [12:0] p,
                              input logic [13:0] i, input logic v, rd);
    vec_t t;
    t.r = r; t.s = s; t.ld = ld; t.ps = ps; t.pp = pp; t.a = a;
    t.q = q; t.p = p; t.i = i; t.v = v; t.rd = rd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_q4();
    for (int k = 0; k < 8 && q_phase != 2'd3; k++) step();
    chk("reach_q4", 32'(q_phase), 32'd3);
  endtask

  task automatic cmd(input logic ld, ps, pp, input logic [12:0] a);
    to_q4();
    pc_load_en = ld; push_en = ps; pop_en = pp; pc_load_addr = a;
    step();
    pc_load_en = 1'b0; push_en = 1'b0; pop_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [12:0] tgt(input int k);
    return 13'(13'h200 + k * 16);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [12:0] pc_hold;
    logic [13:0] ir_hold;

    rst = 1'b1; stall = 1'b0; pc_load_en = 1'b0; push_en = 1'b0; pop_en = 1'b0;
    pc_load_addr = '0;

    // r s ld ps pp addr     | q  pc      ir        v  rd
    vt.push_back(mk(1,0,0,0,0,13'h000, 0,13'h000,14'h0000,0,0)); // reset
    vt.push_back(mk(0,0,0,0,1,13'h000, 1,13'h000,14'h0000,0,0)); // pop outside Q4 ignored
    vt.push_back(mk(0,0,0,0,0,13'h000, 2,13'h000,14'h0000,0,0));
    vt.push_back(mk(0,0,0,0,0,13'h000, 3,13'h000,14'h0000,0,1)); // first fetch addr 0
    vt.push_back(mk(0,0,0,0,0,13'h000, 0,13'h001,14'h0000,0,0));
    vt.push_back(mk(0,0,0,0,0,13'h000, 1,13'h001,14'h0000,1,0)); // mem[0] at 2nd Q1
    vt.push_back(mk(0,0,0,0,0,13'h000, 2,13'h001,14'h0000,1,0));
    vt.push_back(mk(0,0,0,0,0,13'h000, 3,13'h001,14'h0000,1,1));
    vt.push_back(mk(0,0,0,0,0,13'h000, 0,13'h002,14'h0000,1,0));
    vt.push_back(mk(0,0,0,0,0,13'h000, 1,13'h002,14'h30AB,1,0)); // mem[1] at 3rd Q1
    vt.push_back(mk(0,0,0,0,0,13'h000, 2,13'h002,14'h30AB,1,0));
    vt.push_back(mk(0,0,0,0,0,13'h000, 3,13'h002,14'h30AB,1,1));
    vt.push_back(mk(0,0,0,0,0,13'h000, 0,13'h003,14'h30AB,1,0));
    vt.push_back(mk(0,0,1,0,0,13'h055, 1,13'h003,14'h2800,1,0)); // jump in Q1 ignored
    vt.push_back(mk(0,0,1,0,0,13'h055, 2,13'h003,14'h2800,1,0)); // jump in Q2 ignored
    vt.push_back(mk(0,0,0,0,0,13'h000, 3,13'h003,14'h2800,1,1));
    vt.push_back(mk(0,0,1,0,0,13'h000, 0,13'h000,14'h2800,1,0)); // jump to 0 at pc=3
    vt.push_back(mk(0,0,0,0,0,13'h000, 1,13'h000,14'h0000,0,0)); // flushed NOP
    vt.push_back(mk(0,0,0,0,0,13'h000, 2,13'h000,14'h0000,0,0));
    vt.push_back(mk(0,0,0,0,0,13'h000, 3,13'h000,14'h0000,0,1)); // refetch addr 0
    vt.push_back(mk(0,0,0,0,0,13'h000, 0,13'h001,14'h0000,0,0));
    vt.push_back(mk(0,0,0,0,0,13'h000, 1,13'h001,14'h0000,1,0));
    vt.push_back(mk(0,0,0,0,0,13'h000, 2,13'h001,14'h0000,1,0));
    vt.push_back(mk(0,0,0,0,0,13'h000, 3,13'h001,14'h0000,1,1));
    vt.push_back(mk(0,0,0,0,0,13'h000, 0,13'h002,14'h0000,1,0));
    vt.push_back(mk(0,0,0,0,0,13'h000, 1,13'h002,14'h30AB,1,0));

    for (int n = 0; n < vt.size(); n++) begin
      rst = vt[n].r; stall = vt[n].s; pc_load_en = vt[n].ld; push_en = vt[n].ps;
      pop_en = vt[n].pp; pc_load_addr = vt[n].a;
      step();
      chk($sformatf("vec%0d{q,pc,ir,vld,rd}", n),
          32'({q_phase, pc, ir, ir_valid, mif.mem_rd_en}),
          32'({vt[n].q, vt[n].p, vt[n].i, vt[n].v, vt[n].rd}));
    end
    rst = 1'b0; pc_load_en = 1'b0; pop_en = 1'b0; push_en = 1'b0;
    chk("stk_unf_after_ignored_pop", 32'(stk_unf), 32'd0);

    // Call to 0x100 from pc=5, then return three instruction cycles later.
    do_reset();
    cmd(1'b1, 1'b0, 1'b0, 13'h005);
    chk("call_setup_pc", 32'(pc), 32'h005);
    cmd(1'b1, 1'b1, 1'b0, 13'h100);
    chk("call_pc", 32'(pc), 32'h100);
    chk("call_stack0", 32'(dut.u_stk.stk_q[0]), 32'h005);
    chk("call_sp", 32'(dut.u_stk.sp_q), 32'd1);
    step();
    chk("call_nop_vld", 32'(ir_valid), 32'd0);
    to_q4();
    chk("call_fetch_addr", 32'({mif.mem_rd_en, mif.mem_addr}), 32'({1'b1, 13'h100}));
    step(); step();
    chk("call_target_ir", 32'({ir_valid, ir}), 32'({1'b1, 14'h3100}));
    to_q4(); step();
    chk("pre_ret_pc", 32'(pc), 32'h102);
    cmd(1'b1, 1'b1, 1'b1, 13'h777);  // pop outranks load/push
    chk("ret_pc", 32'(pc), 32'h005);
    chk("ret_sp", 32'(dut.u_stk.sp_q), 32'd0);
    chk("ret_count", 32'(dut.u_stk.count_q), 32'd0);
    chk("ret_unf", 32'(stk_unf), 32'd0);
    step();
    chk("ret_nop_vld", 32'(ir_valid), 32'd0);

    // Nine nested calls overflow the 8-deep stack; nine returns underflow it.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      cmd(1'b1, 1'b1, 1'b0, tgt(k));
      if (k == 8) chk("ovf_after_8", 32'(stk_ovf), 32'd0);
    end
    chk("ovf_after_9", 32'(stk_ovf), 32'd1);
    chk("count_full", 32'(dut.u_stk.count_q), 32'd8);
    for (int j = 1; j <= 9; j++) begin
      cmd(1'b0, 1'b0, 1'b1, 13'h000);
      chk($sformatf("ret%0d_pc", j), 32'(pc), 32'(tgt(j <= 8 ? 9 - j : 8)));
      if (j == 8) chk("unf_after_8", 32'(stk_unf), 32'd0);
    end
    chk("unf_after_9", 32'(stk_unf), 32'd1);
    chk("count_empty", 32'(dut.u_stk.count_q), 32'd0);

    // Stall for five clocks in Q2, then resume.
    do_reset();
    chk("reset_clears_flags", 32'({stk_ovf, stk_unf}), 32'd0);
    to_q4(); step(); step();
    to_q4(); step(); step();
    pc_hold = pc; ir_hold = ir;
    chk("pre_stall_state", 32'({q_phase, pc, ir}), 32'({2'd1, 13'h002, 14'h30AB}));
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("stall%0d{q,pc,ir,rd}", k), 32'({q_phase, pc, ir, mif.mem_rd_en}),
          32'({2'd1, pc_hold, ir_hold, 1'b0}));
    end
    stall = 1'b0;
    step();
    chk("resume_q", 32'(q_phase), 32'd2);
    step();
    chk("resume_fetch", 32'({mif.mem_rd_en, mif.mem_addr}), 32'({1'b1, 13'h002}));
    step(); step();
    chk("resume_ir", 32'({pc, ir}), 32'({13'h003, 14'h2800}));
    to_q4();
    stall = 1'b1; pc_load_en = 1'b1; pc_load_addr = 13'h123;
    step(); step();
    chk("stall_q4{q,pc,rd}", 32'({q_phase, pc, mif.mem_rd_en}), 32'({2'd3, 13'h003, 1'b0}));
    stall = 1'b0; pc_load_en = 1'b0;
    step();
    chk("stall_q4_release_pc", 32'(pc), 32'h004);

    // pc wraps from 0x1FFF to 0.
    cmd(1'b1, 1'b0, 1'b0, 13'h1FFF);
    chk("wrap_setup", 32'(pc), 32'h1FFF);
    to_q4();
    step();
    chk("wrap_pc", 32'(pc), 32'h0000);

    // Reset in Q3 with a call command held drops everything.
    cmd(1'b1, 1'b1, 1'b0, 13'h300);
    to_q4(); step(); step(); step();
    chk("pre_rst{q,vld,sp}", 32'({q_phase, ir_valid, dut.u_stk.sp_q}), 32'({2'd2, 1'b1, 3'd1}));
    rst = 1'b1; pc_load_en = 1'b1; push_en = 1'b1; pc_load_addr = 13'h444;
    step();
    rst = 1'b0; pc_load_en = 1'b0; push_en = 1'b0;
    chk("midrst{q,pc,ir,vld}", 32'({q_phase, pc, ir, ir_valid}), 32'd0);
    chk("midrst_sp", 32'(dut.u_stk.sp_q), 32'd0);
    chk("midrst_count", 32'(dut.u_stk.count_q), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
